// File: rtl/proj_topk_sorter.sv
`default_nettype none
// ============================================================================
// Module      : proj_topk_sorter
// Description : Streaming bottom-K (MinHash) selector with an ordered table,
//               then an in-order drain of the kept indices.
// Revision    : 1.0 - initial release
// ============================================================================

package proj_pkg;
    localparam int SORTER_EXTENDER_INDICES_COUNT = 8;
    localparam int INDICE_LEN                    = 16;
    localparam int HASHER_SORTER_SIGNATURE       = 32;
    localparam int SORTER_POSITION_LEN           = $clog2(SORTER_EXTENDER_INDICES_COUNT);
endpackage

module proj_topk_sorter #(
    parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
    parameter int INDICE_LEN    = proj_pkg::INDICE_LEN,
    parameter int SIGNATURE_LEN = proj_pkg::HASHER_SORTER_SIGNATURE,
    parameter int POSITION_LEN  = proj_pkg::SORTER_POSITION_LEN,
    parameter bit DEDUP_EN      = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sort_clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIGNATURE_LEN-1:0] in_signature,
    input  logic [INDICE_LEN-1:0]    in_index,
    input  logic                     end_sorting,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INDICE_LEN-1:0]    out_index,
    output logic [POSITION_LEN-1:0]  out_rank,
    output logic                     out_last,
    output logic [POSITION_LEN:0]    out_count,
    output logic                     sort_done
);

    localparam logic [POSITION_LEN:0] c_K   = (POSITION_LEN+1)'(INDICES_COUNT);
    localparam logic [POSITION_LEN:0] c_ONE = (POSITION_LEN+1)'(1);
    localparam logic [POSITION_LEN:0] c_ZERO = '0;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_DRAIN   = 1'b1;

    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;

    logic [SIGNATURE_LEN-1:0] r_sig [INDICES_COUNT];
    logic [INDICE_LEN-1:0]    r_idx [INDICES_COUNT];
    logic [SIGNATURE_LEN-1:0] w_sig_nxt [INDICES_COUNT];
    logic [INDICE_LEN-1:0]    w_idx_nxt [INDICES_COUNT];

    logic [POSITION_LEN:0]    r_fill;
    logic [POSITION_LEN:0]    r_rd_ptr;
    logic                     r_sort_done;

    logic [INDICES_COUNT-1:0] w_le;
    logic [INDICES_COUNT-1:0] w_eq;
    logic [POSITION_LEN:0]    w_pos;
    logic [POSITION_LEN:0]    w_fill_ins;
    logic [POSITION_LEN:0]    w_fill_nxt;
    logic                     w_accept;
    logic                     w_dup;
    logic                     w_insert;
    logic                     w_end;
    logic                     w_out_valid;
    logic                     w_out_last;
    logic                     w_out_fire;
    logic                     w_drain_done;

    // ------------------------------------------------------------------
    // Insertion position: count of valid entries not greater than input,
    // so equal signatures land behind earlier arrivals.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < INDICES_COUNT; gi++) begin : g_slot
        localparam logic [POSITION_LEN:0] c_SLOT = (POSITION_LEN+1)'(gi);

        assign w_le[gi] = (c_SLOT < r_fill) && (r_sig[gi] <= in_signature);
        assign w_eq[gi] = (c_SLOT < r_fill) && (r_sig[gi] == in_signature);

        if (gi == 0) begin : g_head
            assign w_sig_nxt[gi] = (w_pos == c_ZERO) ? in_signature : r_sig[gi];
            assign w_idx_nxt[gi] = (w_pos == c_ZERO) ? in_index     : r_idx[gi];
        end else begin : g_body
            assign w_sig_nxt[gi] = (c_SLOT < w_pos)  ? r_sig[gi]    :
                                   (c_SLOT == w_pos) ? in_signature : r_sig[gi-1];
            assign w_idx_nxt[gi] = (c_SLOT < w_pos)  ? r_idx[gi]    :
                                   (c_SLOT == w_pos) ? in_index     : r_idx[gi-1];
        end
    end

    assign w_pos       = (POSITION_LEN+1)'($countones(w_le));
    assign w_accept    = (r_state == ST_COLLECT) && in_valid && !sort_clear;
    assign w_dup       = (DEDUP_EN != 1'b0) && (|w_eq);
    assign w_insert    = w_accept && !w_dup && (w_pos != c_K);
    assign w_fill_ins  = (r_fill == c_K) ? c_K : (r_fill + c_ONE);
    assign w_fill_nxt  = w_insert ? w_fill_ins : r_fill;

    assign w_end       = (r_state == ST_COLLECT) && end_sorting && !sort_clear;
    assign w_out_valid = (r_state == ST_DRAIN) && (r_rd_ptr < r_fill);
    assign w_out_last  = w_out_valid && ((r_rd_ptr + c_ONE) == r_fill);
    assign w_out_fire  = w_out_valid && out_ready;

    // An empty set completes in the same edge that sees end_sorting.
    assign w_drain_done = (w_end && (w_fill_nxt == c_ZERO)) ||
                          ((r_state == ST_DRAIN) && w_out_fire && w_out_last && !sort_clear);

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (sort_clear) begin
            w_state_nxt = ST_COLLECT;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (end_sorting) begin
                        w_state_nxt = (w_fill_nxt == c_ZERO) ? ST_COLLECT : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_fire && w_out_last) begin
                        w_state_nxt = ST_COLLECT;
                    end
                end
                default: w_state_nxt = ST_COLLECT;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == ST_COLLECT);
        out_valid = w_out_valid;
        out_index = w_out_valid ? r_idx[r_rd_ptr[POSITION_LEN-1:0]] : '0;
        out_rank  = w_out_valid ? r_rd_ptr[POSITION_LEN-1:0] : '0;
        out_last  = w_out_last;
        out_count = r_fill;
        sort_done = r_sort_done;
    end

    // ------------------------------------------------------------------
    // Fill count, read pointer and completion pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill      <= '0;
            r_rd_ptr    <= '0;
            r_sort_done <= 1'b0;
        end else begin
            r_sort_done <= w_drain_done;

            if (sort_clear || w_drain_done) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_nxt;
            end

            if (sort_clear || w_drain_done || (r_state == ST_COLLECT)) begin
                r_rd_ptr <= '0;
            end else if (w_out_fire) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
        end
    end

    // Whole table shifts in one edge; the last entry falls off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < INDICES_COUNT; i++) begin
                r_sig[i] <= '0;
                r_idx[i] <= '0;
            end
        end else if (w_insert) begin
            for (int i = 0; i < INDICES_COUNT; i++) begin
                r_sig[i] <= w_sig_nxt[i];
                r_idx[i] <= w_idx_nxt[i];
            end
        end
    end

endmodule

`default_nettype wire
